// File: rtl/frame_read_select.sv
// frame_read_select
// Read-side bank selector and pixel address generator for a ping-pong
// frame buffer. Tracks which bank holds the newest complete frame. On each
// display frame start it locks that bank for the whole read. It then streams
// bank-qualified pixel addresses over a valid/ready handshake.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   wr_bank        writer's current bank
//   wr_frame_done  pulse: frame in wr_bank (same cycle) is complete
//   rd_start       pulse: request one frame read (vsync)
//   rd_ready       downstream accepts rd_addr
//   rd_valid       rd_addr valid
//   rd_addr        {rd_bank, pixel index}, index = y*H_RES + x
//   rd_eol/rd_eof  last pixel of line / frame (qualified by rd_valid)
//   rd_bank        bank locked for current / most recent read
//   rd_repeat      current read re-uses the previous bank (no new frame)
//   rd_miss        pulse: an rd_start was dropped
//   collision      registered: writer is in the bank being read
module frame_read_select #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_bank,
    input  logic              wr_frame_done,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W:0]   rd_addr,
    output logic              rd_eol,
    output logic              rd_eof,
    output logic              rd_bank,
    output logic              rd_repeat,
    output logic              rd_miss,
    output logic              collision
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] idx;
    logic              have_frame;
    logic              fresh;
    logic              last_bank;

    logic x_last, y_last, xfer, start_ok;

    assign x_last   = (x == XW'(H_RES - 1));
    assign y_last   = (y == YW'(V_RES - 1));
    assign xfer     = (state == READ) && rd_ready;
    // A done on the same cycle as the start counts as an available frame.
    assign start_ok = (state == IDLE) && rd_start && (have_frame || wr_frame_done);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = READ;
            READ: if (xfer && x_last && y_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        rd_valid = (state == READ);
        rd_eol   = rd_valid && x_last;
        rd_eof   = rd_valid && x_last && y_last;
        rd_addr  = {rd_bank, idx};
    end

    // ---------------- completion tracking ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_frame <= 1'b0;
            fresh      <= 1'b0;
            last_bank  <= 1'b0;
        end else begin
            if (wr_frame_done) begin
                have_frame <= 1'b1;
                last_bank  <= wr_bank;
            end
            // A start consumes freshness, including a done bypassed
            // straight into this read.
            if (start_ok)           fresh <= 1'b0;
            else if (wr_frame_done) fresh <= 1'b1;
        end
    end

    // ---------------- bank lock and pixel counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank   <= 1'b0;
            rd_repeat <= 1'b0;
            x         <= '0;
            y         <= '0;
            idx       <= '0;
        end else if (start_ok) begin
            rd_bank   <= wr_frame_done ? wr_bank : last_bank;
            rd_repeat <= !wr_frame_done && !fresh;
            x         <= '0;
            y         <= '0;
            idx       <= '0;
        end else if (xfer && !(x_last && y_last)) begin
            // The last pixel leaves the counters untouched so rd_addr keeps
            // showing the final address while idle.
            idx <= idx + 1'b1;
            if (x_last) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // ---------------- status pulses ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_miss   <= 1'b0;
            collision <= 1'b0;
        end else begin
            rd_miss   <= rd_start && ((state == READ) || (!have_frame && !wr_frame_done));
            collision <= (state == READ) && (wr_bank == rd_bank);
        end
    end

endmodule

// File: tb/tb_frame_read_select.sv
// Randomized + directed bench for frame_read_select, checked against a
// pixel-count level reference model.
module tb_frame_read_select;

    localparam int H = 4;
    localparam int V = 2;
    localparam int A = 3;
    localparam int N = H * V;

    logic         clk = 0;
    logic         rst = 0;
    logic         wr_bank = 0, wr_frame_done = 0, rd_start = 0, rd_ready = 0;
    logic         rd_valid, rd_eol, rd_eof, rd_bank, rd_repeat, rd_miss, collision;
    logic [A:0]   rd_addr;

    frame_read_select #(.H_RES(H), .V_RES(V), .ADDR_W(A)) dut (
        .clk(clk), .rst(rst), .wr_bank(wr_bank), .wr_frame_done(wr_frame_done),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_eol(rd_eol), .rd_eof(rd_eof), .rd_bank(rd_bank),
        .rd_repeat(rd_repeat), .rd_miss(rd_miss), .collision(collision)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a run of N pixels counted by m_pos.
    bit m_busy, m_bank, m_rep, m_have, m_fresh, m_last, m_miss, m_coll;
    int m_pos;

    task automatic model_reset();
        m_busy = 0; m_bank = 0; m_rep = 0; m_have = 0; m_fresh = 0;
        m_last = 0; m_miss = 0; m_coll = 0; m_pos = 0;
    endtask

    task automatic check_outputs();
        chk("valid",     int'(rd_valid),  int'(m_busy));
        chk("addr",      int'(rd_addr),   (int'(m_bank) << A) | m_pos);
        chk("eol",       int'(rd_eol),    int'(m_busy && (m_pos % H) == H - 1));
        chk("eof",       int'(rd_eof),    int'(m_busy && m_pos == N - 1));
        chk("bank",      int'(rd_bank),   int'(m_bank));
        chk("repeat",    int'(rd_repeat), int'(m_rep));
        chk("miss",      int'(rd_miss),   int'(m_miss));
        chk("collision", int'(collision), int'(m_coll));
    endtask

    // Called at a negedge: check, drive, advance model, move to next negedge.
    task automatic step(input bit s, input bit d, input bit b, input bit r);
        bit started;
        check_outputs();
        rd_start = s; wr_frame_done = d; wr_bank = b; rd_ready = r;
        started = 0;
        m_coll  = m_busy && (b == m_bank);
        m_miss  = s && (m_busy || (!m_have && !d));
        if (m_busy) begin
            if (r) begin
                if (m_pos == N - 1) m_busy = 0;
                else                m_pos++;
            end
        end else if (s && (m_have || d)) begin
            m_bank  = d ? b : m_last;
            m_rep   = !d && !m_fresh;
            m_busy  = 1;
            m_pos   = 0;
            started = 1;
        end
        if (d) begin
            m_have = 1; m_fresh = 1; m_last = b;
        end
        if (started) m_fresh = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(0, 0, 0, r);
    endtask

    // Asynchronous reset asserted at a negedge; outputs must clear at once.
    task automatic async_reset();
        rst = 1;
        #1;
        chk("rst_valid",  int'(rd_valid),  0);
        chk("rst_addr",   int'(rd_addr),   0);
        chk("rst_eol",    int'(rd_eol),    0);
        chk("rst_eof",    int'(rd_eof),    0);
        chk("rst_bank",   int'(rd_bank),   0);
        chk("rst_repeat", int'(rd_repeat), 0);
        chk("rst_miss",   int'(rd_miss),   0);
        chk("rst_coll",   int'(collision), 0);
        model_reset();
        rd_start = 0; wr_frame_done = 0; rd_ready = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        async_reset();

        // start with no frame ever completed -> miss, no read
        step(1, 0, 0, 1);
        idle(3, 1);

        // bank 0 frame, full-speed read
        step(0, 1, 0, 0);
        step(1, 0, 0, 1);
        idle(10, 1);

        // backpressure pattern 1,0,0,1,...
        step(1, 0, 0, 1);
        for (int i = 0; i < 24; i++) step(0, 0, 0, (i % 4 == 0) || (i % 4 == 3));
        idle(2, 1);

        // bank 1 frame, then read twice (second is a repeat)
        step(0, 1, 1, 0);
        step(1, 0, 0, 1);
        idle(10, 1);
        step(1, 0, 0, 1);
        idle(10, 1);

        // done on bank 1 coincides with start while last_bank=0, fresh=0
        step(0, 1, 0, 0);
        step(1, 0, 0, 1);
        idle(10, 1);
        step(1, 1, 1, 1);
        idle(10, 1);
        step(1, 0, 0, 1);
        idle(10, 1);

        // start during read (at index 5) with writer in the read bank
        step(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        idle(2, 1);

        // reset at index 2 of a new frame
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        async_reset();
        idle(3, 1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            else step($urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
